// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixup at the end.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes and one datapath step, shared by mult and div
    always_comb begin
        is_signed = (op == 3'd0) || (op == 3'd2);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        accept    = start && !cancel &&
                    ((state == S_IDLE) || (state == S_DONE));
        mul_sum   = {1'b0, acc_hi} +
                    {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
        div_sh    = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, opnd};
        // Partial remainder after subtraction is below the divisor, so it fits
        div_diff  = div_sh[WIDTH-1:0] - opnd;
        prod      = {acc_hi, acc_lo};
    end

    assign busy = (state == S_CALC) || (state == S_FIXUP);

    // Control FSM, iterative datapath and HI/LO commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (accept) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                state   <= S_CALC;
                                cnt     <= '0;
                                is_div  <= op[1];
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                                b_zero  <= (b == '0);
                                acc_hi  <= '0;
                                acc_lo  <= op[1] ? a_mag : b_mag;
                                opnd    <= op[1] ? b_mag : a_mag;
                            end
                            3'd4: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            3'd5: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            acc_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIXUP;
                        end
                    end
                end
                S_FIXUP: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (is_div) begin
                            // Divide by zero leaves the all-ones quotient and hi=a
                            lo <= b_zero  ? {WIDTH{1'b1}} :
                                  neg_res ? -acc_lo : acc_lo;
                            hi <= neg_rem ? -acc_hi : acc_hi;
                        end else begin
                            {hi, lo} <= neg_res ? -prod : prod;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32).
// Stimulus pushes expected {hi,lo}; a monitor pops on every done pulse.
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] sb_q[$];
    logic [W-1:0]   exp_hi = '0;
    logic [W-1:0]   exp_lo = '0;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: hi=%h lo=%h, no op pending",
                         hi, lo);
            end else begin
                logic [2*W-1:0] e;
                e = sb_q.pop_front();
                chk("sb_hi", 64'(hi), 64'(e[2*W-1:W]));
                chk("sb_lo", 64'(lo), 64'(e[W-1:0]));
                chk("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        bit arith;
        arith = (o <= 3'd3);
        sb_q.push_back({ehi, elo});
        exp_hi = ehi;
        exp_lo = elo;
        start = 1'b1;
        op = o;
        a = ra;
        b = rb;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        chk({tag, "_busy"}, 64'(busy), 64'(arith));
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), arith ? 64'd34 : 64'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        @(negedge clk);
        chk("done_drop", 64'(done), 64'd0);
        run_op("multu", 3'd1, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
        run_op("divu_b2b", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        @(negedge clk);
        run_op("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("div_z", 3'd2, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
        run_op("div_zneg", 3'd2, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("divu_z", 3'd3, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
        @(negedge clk);

        // MTHI then MTLO on consecutive edges
        sb_q.push_back({32'hA5A5A5A5, exp_lo});
        sb_q.push_back({32'hA5A5A5A5, 32'h5A5A5A5A});
        exp_hi = 32'hA5A5A5A5;
        exp_lo = 32'h5A5A5A5A;
        start = 1'b1;
        op = 3'd4;
        a = 32'hA5A5A5A5;
        @(negedge clk);
        op = 3'd5;
        a = 32'h5A5A5A5A;
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd1);
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("mt_done_drop", 64'(done), 64'd0);

        // Cancel at edge k+10; a start while busy must be ignored
        start = 1'b1;
        op = 3'd0;
        a = 32'd3;
        b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 10; n++) begin
            if (n == 3) begin
                start = 1'b1;
                op = 3'd4;
                a = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_hi", 64'(hi), 64'(exp_hi));
        chk("cancel_lo", 64'(lo), 64'(exp_lo));

        // cancel together with start in IDLE: start ignored
        cancel = 1'b1;
        start = 1'b1;
        op = 3'd4;
        a = 32'h0BADF00D;
        @(negedge clk);
        cancel = 1'b0;
        start = 1'b0;
        chk("cancel_start_done", 64'(done), 64'd0);
        chk("cancel_start_hi", 64'(hi), 64'(exp_hi));

        // Asynchronous reset mid-CALC
        start = 1'b1;
        op = 3'd1;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        @(negedge clk);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
